// File: rtl/servant_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 32-bit Wishbone slave.
// Reading mtime[31:0] snapshots mtime[63:32] so that a following hi read is coherent.
module servant_mtimer #(
    parameter int unsigned DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          mtip_q, mtip_d;

    logic          accept;
    logic          tick;
    logic [31:0]   rdata;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        accept = i_wb_cyc & ~ack_q;
        tick   = (pcnt_q == PMAX);

        unique case (i_wb_adr)
            2'd0:    rdata = mtime_q[31:0];
            2'd1:    rdata = shadow_q;
            2'd2:    rdata = mtimecmp_q[31:0];
            default: rdata = mtimecmp_q[63:32];
        endcase

        pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
        mtime_d    = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;

        // An mtime write replaces the incremented value outright, so the
        // untouched half keeps its pre-edge value with no carry.
        if (accept && i_wb_we) begin
            unique case (i_wb_adr)
                2'd0: begin
                    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wb_dat, i_wb_sel)};
                    pcnt_d  = '0;
                end
                2'd1: begin
                    mtime_d = {merge_bytes(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
                    pcnt_d  = '0;
                end
                2'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], i_wb_dat, i_wb_sel);
                default: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
            endcase
        end

        if (accept && !i_wb_we && (i_wb_adr == 2'd0)) shadow_d = mtime_q[63:32];

        dat_d  = accept ? rdata : dat_q;
        ack_d  = accept;
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            shadow_q   <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            mtip_q     <= mtip_d;
        end
    end

    assign o_wb_dat = dat_q;
    assign o_wb_ack = ack_q;
    assign o_mtip   = mtip_q;

endmodule
